// File: rtl/issue_scoreboard.sv
// Scoreboard issue controller: stalls RAW/WAW hazards on outstanding long-latency
// writes, drains outstanding writes before fences, and issues through a one-entry register.
module issue_scoreboard #(
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [4:0]            s_rs1,
    input  logic [4:0]            s_rs2,
    input  logic [4:0]            s_rd,
    input  logic                  s_long,
    input  logic                  s_fence,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    input  logic                  invalidate,
    output logic [31:0]           busy_o,
    output logic [3:0]            outstanding_o
);
    typedef enum logic {RUN, FENCE_WAIT} state_t;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t                state, state_nxt;
    logic [31:0]           busy;
    logic [3:0]            outstanding;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    logic        free, hazard, accept, set_en, clr_en;
    logic [31:0] set_vec, clr_vec;

    assign free   = !vld_p1 || m_tready;
    // Only the registered busy vector is consulted, so a writeback frees its
    // dependants one cycle later.
    assign hazard = busy[s_rs1] || busy[s_rs2] ||
                    (busy[s_rd] && (s_rd != 5'd0)) ||
                    (s_long && (s_rd != 5'd0) && (outstanding == MAX_OUT));

    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        case (state)
            RUN: begin
                if (s_tvalid && s_fence && (outstanding != 4'd0))
                    state_nxt = FENCE_WAIT;
                else
                    s_tready = free && !hazard;
            end
            FENCE_WAIT: begin
                if (outstanding == 4'd0)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (invalidate) begin
            s_tready  = 1'b0;
            state_nxt = RUN;
        end
    end

    assign accept  = s_tvalid && s_tready;
    assign set_en  = accept && s_long && (s_rd != 5'd0);
    assign clr_en  = wb_valid && (wb_rd != 5'd0) && busy[wb_rd];
    assign set_vec = set_en ? (32'd1 << s_rd) : 32'd0;
    assign clr_vec = clr_en ? (32'd1 << wb_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            busy        <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (busy & ~clr_vec) | set_vec;
            if (set_en && !clr_en)
                outstanding <= outstanding + 4'd1;
            else if (clr_en && !set_en)
                outstanding <= outstanding - 4'd1;
        end
    end

    // Issue stage boundary: invalidate drops the held instruction ahead of any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (invalidate) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= s_tdata;
        end else if (free) begin
            vld_p1 <= 1'b0;
        end
    end

    a_wb_legal: assert property (@(posedge clk) disable iff (rst)
        wb_valid |-> ((wb_rd != 5'd0) && busy[wb_rd]));

    assign m_tvalid      = vld_p1;
    assign m_tdata       = data_p1;
    assign busy_o        = busy;
    assign outstanding_o = outstanding;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: scripted scenario vectors followed by randomized
// traffic checked against a register-set reference model.
module tb_issue_scoreboard;
    localparam int DW   = 128;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid, s_tready, s_long, s_fence;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [4:0]    s_rs1, s_rs2, s_rd, wb_rd;
    logic          m_tvalid, m_tready, wb_valid, invalidate;
    logic [31:0]   busy_o;
    logic [3:0]    outstanding_o;

    int n_tests = 0;
    int n_fail  = 0;

    issue_scoreboard #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd(s_rd), .s_long(s_long), .s_fence(s_fence),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .invalidate(invalidate),
        .busy_o(busy_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        lng, fen, mr, wv;
        logic [4:0]  wrd;
        logic        inv;
        logic [7:0]  tag;
        logic        rdy, mv;
        logic [7:0]  md;
        logic [3:0]  outs;
        logic [31:0] bsy;
    } vec_t;

    function automatic vec_t mk(input int v, input int rs1, input int rs2, input int rd,
                                input int lng, input int fen, input int mr, input int wv,
                                input int wrd, input int inv, input int tag,
                                input int rdy, input int mv, input int md,
                                input int outs, input int bsy);
        vec_t r;
        r.v = 1'(v); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.lng = 1'(lng); r.fen = 1'(fen); r.mr = 1'(mr); r.wv = 1'(wv);
        r.wrd = 5'(wrd); r.inv = 1'(inv); r.tag = 8'(tag);
        r.rdy = 1'(rdy); r.mv = 1'(mv); r.md = 8'(md);
        r.outs = 4'(outs); r.bsy = 32'(bsy);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        s_tvalid = r.v; s_rs1 = r.rs1; s_rs2 = r.rs2; s_rd = r.rd;
        s_long = r.lng; s_fence = r.fen; m_tready = r.mr;
        wb_valid = r.wv; wb_rd = r.wrd; invalidate = r.inv;
        s_tdata = {120'd0, r.tag};
    endtask

    task automatic run_vec(input vec_t r, input string nm);
        drive(r);
        #1;
        chk({nm, ".s_tready"}, DW'(s_tready), DW'(r.rdy));
        @(posedge clk); #1;
        chk({nm, ".m_tvalid"}, DW'(m_tvalid), DW'(r.mv));
        if (r.mv) chk({nm, ".m_tdata"}, m_tdata, {120'd0, r.md});
        chk({nm, ".outstanding"}, DW'(outstanding_o), DW'(r.outs));
        chk({nm, ".busy"}, DW'(busy_o), DW'(r.bsy));
    endtask

    task automatic do_reset(input string nm);
        drive(mk(0,0,0,0,0,0,1,0,0,0,0, 0,0,0,0,0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk({nm, ".m_tvalid"}, DW'(m_tvalid), '0);
        chk({nm, ".m_tdata"}, m_tdata, '0);
        chk({nm, ".busy"}, DW'(busy_o), '0);
        chk({nm, ".outstanding"}, DW'(outstanding_o), '0);
    endtask

    // Reference model state: set of registers with a pending long write.
    bit            mb[32];
    bit            fw, mvm;
    logic [DW-1:0] mdm;

    function automatic logic [31:0] pack_busy();
        logic [31:0] p = '0;
        for (int i = 0; i < 32; i++) p[i] = mb[i];
        return p;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mb[i]);
        return n;
    endfunction

    vec_t tbl[24];

    initial begin
        // Independent ALU ops, then a load with a dependent add.
        tbl[0]  = mk(1,1,2,3,0,0,1,0,0,0,'h11, 1,1,'h11,0,0);
        tbl[1]  = mk(1,0,0,4,0,0,1,0,0,0,'h12, 1,1,'h12,0,0);
        tbl[2]  = mk(1,0,0,5,0,0,1,0,0,0,'h13, 1,1,'h13,0,0);
        tbl[3]  = mk(1,0,0,5,1,0,1,0,0,0,'h20, 1,1,'h20,1,'h20);
        tbl[4]  = mk(1,5,0,6,0,0,1,0,0,0,'h21, 0,0,0,1,'h20);
        tbl[5]  = mk(1,5,0,6,0,0,1,0,0,0,'h21, 0,0,0,1,'h20);
        tbl[6]  = mk(1,5,0,6,0,0,1,1,5,0,'h21, 0,0,0,0,0);
        tbl[7]  = mk(1,5,0,6,0,0,1,0,0,0,'h21, 1,1,'h21,0,0);
        // Fill to MAX_OUTSTANDING, fifth load waits for a writeback.
        tbl[8]  = mk(1,0,0,1,1,0,1,0,0,0,'h31, 1,1,'h31,1,'h02);
        tbl[9]  = mk(1,0,0,2,1,0,1,0,0,0,'h32, 1,1,'h32,2,'h06);
        tbl[10] = mk(1,0,0,3,1,0,1,0,0,0,'h33, 1,1,'h33,3,'h0E);
        tbl[11] = mk(1,0,0,4,1,0,1,0,0,0,'h34, 1,1,'h34,4,'h1E);
        tbl[12] = mk(1,0,0,6,1,0,1,0,0,0,'h35, 0,0,0,4,'h1E);
        tbl[13] = mk(1,0,0,6,1,0,1,1,2,0,'h35, 0,0,0,3,'h1A);
        tbl[14] = mk(1,0,0,6,1,0,1,0,0,0,'h35, 1,1,'h35,4,'h5A);
        // Output back-pressure for three cycles, then release.
        tbl[15] = mk(1,0,0,7,0,0,0,0,0,0,'h41, 0,1,'h35,4,'h5A);
        tbl[16] = mk(1,0,0,7,0,0,0,0,0,0,'h41, 0,1,'h35,4,'h5A);
        tbl[17] = mk(1,0,0,7,0,0,0,0,0,0,'h41, 0,1,'h35,4,'h5A);
        tbl[18] = mk(1,0,0,7,0,0,1,0,0,0,'h41, 1,1,'h41,4,'h5A);
        // Drain, then a long op targeting x0 is untracked.
        tbl[19] = mk(0,0,0,0,0,0,1,1,1,0,0, 1,0,0,3,'h58);
        tbl[20] = mk(0,0,0,0,0,0,1,1,3,0,0, 1,0,0,2,'h50);
        tbl[21] = mk(0,0,0,0,0,0,1,1,4,0,0, 1,0,0,1,'h40);
        tbl[22] = mk(0,0,0,0,0,0,1,1,6,0,0, 1,0,0,0,0);
        tbl[23] = mk(1,0,0,0,1,0,1,0,0,0,'h50, 1,1,'h50,0,0);

        do_reset("reset0");
        for (int i = 0; i < 24; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Fence with two loads outstanding.
        run_vec(mk(1,0,0,8,1,0,1,0,0,0,'h60, 1,1,'h60,1,'h100), "fence.ld8");
        run_vec(mk(1,0,0,9,1,0,1,0,0,0,'h61, 1,1,'h61,2,'h300), "fence.ld9");
        run_vec(mk(1,0,0,0,0,1,1,0,0,0,'h62, 0,0,0,2,'h300), "fence.enter");
        run_vec(mk(1,0,0,0,0,1,1,1,8,0,'h62, 0,0,0,1,'h200), "fence.wb8");
        run_vec(mk(1,0,0,0,0,1,1,1,9,0,'h62, 0,0,0,0,0), "fence.wb9");
        run_vec(mk(1,0,0,0,0,1,1,0,0,0,'h62, 0,0,0,0,0), "fence.exit");
        run_vec(mk(1,0,0,0,0,1,1,0,0,0,'h62, 1,1,'h62,0,0), "fence.issue");

        // Flush with a load in flight and a held output.
        run_vec(mk(1,0,0,7,1,0,1,0,0,0,'h70, 1,1,'h70,1,'h80), "inv.ld7");
        run_vec(mk(1,0,0,10,0,0,0,0,0,1,'h71, 0,0,0,1,'h80), "inv.flush");
        run_vec(mk(0,0,0,0,0,0,1,1,7,0,0, 1,0,0,0,0), "inv.wb7");
        run_vec(mk(1,0,0,11,0,0,1,0,0,0,'h72, 1,1,'h72,0,0), "inv.next");

        // Randomized traffic against the reference model.
        do_reset("reset1");
        foreach (mb[i]) mb[i] = 1'b0;
        fw = 1'b0; mvm = 1'b0; mdm = '0;
        begin
            logic          cv, took, lng, fen, mr, wv, inv, free, hz, erdy;
            logic [4:0]    rs1, rs2, rd, wrd;
            logic [DW-1:0] data;
            int            cnt;
            cv = 1'b0; took = 1'b0;
            rs1 = '0; rs2 = '0; rd = '0; lng = 1'b0; fen = 1'b0; data = '0;
            for (int c = 0; c < 400; c++) begin
                if (!cv || took) begin
                    cv   = ($urandom_range(0, 3) != 0);
                    rs1  = 5'($urandom_range(0, 7));
                    rs2  = 5'($urandom_range(0, 7));
                    rd   = 5'($urandom_range(0, 7));
                    lng  = ($urandom_range(0, 2) == 0);
                    fen  = ($urandom_range(0, 7) == 0);
                    data = {$urandom, $urandom, $urandom, $urandom};
                end
                mr  = ($urandom_range(0, 3) != 0);
                inv = ($urandom_range(0, 29) == 0);
                wrd = 5'($urandom_range(1, 7));
                wv  = mb[wrd] && ($urandom_range(0, 1) == 1);
                s_tvalid = cv; s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_long = lng;
                s_fence = fen; s_tdata = data; m_tready = mr; wb_valid = wv;
                wb_rd = wrd; invalidate = inv;

                cnt  = count_busy();
                free = !mvm || mr;
                hz   = mb[rs1] || mb[rs2] || mb[rd] || (lng && rd != 0 && cnt == MAXO);
                erdy = !inv && !fw && !(cv && fen && cnt != 0) && free && !hz;
                #1;
                chk($sformatf("rnd%0d.s_tready", c), DW'(s_tready), DW'(erdy));
                took = cv && erdy;

                if (inv)                         fw = 1'b0;
                else if (fw)                     fw = (cnt != 0);
                else if (cv && fen && cnt != 0)  fw = 1'b1;
                if (wv) mb[wrd] = 1'b0;
                if (took && lng && rd != 0) mb[rd] = 1'b1;
                if (inv)        mvm = 1'b0;
                else if (took) begin mvm = 1'b1; mdm = data; end
                else if (free)  mvm = 1'b0;

                @(posedge clk); #1;
                chk($sformatf("rnd%0d.m_tvalid", c), DW'(m_tvalid), DW'(mvm));
                if (mvm) chk($sformatf("rnd%0d.m_tdata", c), m_tdata, mdm);
                chk($sformatf("rnd%0d.outstanding", c), DW'(outstanding_o), DW'(count_busy()));
                chk($sformatf("rnd%0d.busy", c), DW'(busy_o), DW'(pack_busy()));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
